shell_slot_arbiter: RTL
=======================

// Module: shell_slot_arbiter
// PURPOSE
//   Shares a fixed pool of projectile slots between the two tanks (0 = tank A, 1 = tank B).
//   Turns raw shoot requests into one-cycle grants, each tagged with a free slot index.
//   Enforces per-tank ammo, reload and fire cooldown.
//   Sits between the tank movement blocks and the projectile datapath; runs once per frame.
// PARAMETERS
//   NUM_SLOTS  4    projectile slots in pool, legal 2..8; SW = $clog2(NUM_SLOTS)
//   AMMO_MAX   5    shells per tank after reset/reload, legal 1..15
//   COOLDOWN   30   frames between shots of one tank, legal 1..255
//   LIFETIME   120  frames before a slot self-frees (LIFETIME_TIMEOUT_EN only), legal 1..1023
// PORTS
//   frame_clk    in   1          frame-rate clock, all state on rising edge
//   Reset_n      in   1          asynchronous, active-low reset
//   fire_req     in   2          per-tank shoot level; only a 0->1 edge counts
//   reload_req   in   2          per-tank reload level; only a 0->1 edge counts
//   slot_done    in   NUM_SLOTS  per-slot 1-cycle pulse from datapath: shell hit/off-screen
//   grant        out  2          one-hot, 1-cycle pulse: tank whose shot was accepted
//   grant_slot   out  SW         slot index for the grant; valid only while grant != 0
//   slot_busy    out  NUM_SLOTS  1 = slot holds a live shell
//   slot_owner   out  NUM_SLOTS  owning tank per slot; meaningful only when busy
//   ammo0        out  4          tank A shells remaining
//   ammo1        out  4          tank B shells remaining
// BEHAVIOUR
//   Reset (Reset_n = 0, async):
//     grant = 0, grant_slot = 0, slot_busy = 0, slot_owner = 0
//     ammo0 = ammo1 = AMMO_MAX; both tank FSMs READY; pending = 0
//     edge registers = 0; priority pointer = tank A
//     A reset mid-flight drops every live shell and any pending request.
//   Edge detect: rise[i] = fire_req[i] & ~fire_q[i]; fire_q is registered each cycle.
//     A held key fires once. reload_req uses the same scheme.
//   pending[i]:
//     Set by rise[i].
//     Cleared by a grant to tank i or by a reload rise of tank i.
//     Otherwise held, so a shot waits for a free slot.
//   Eligible[i] = (pending[i] | rise[i]) & FSM[i] == READY & ammo[i] != 0 & any slot free.
//   Arbitration:
//     One grant per cycle max.
//     Only one tank eligible -> it wins.
//     Both eligible -> pointer tank wins, and the pointer flips to the other tank.
//     Loser stays pending.
//   Slot choice: lowest-index slot with busy = 0 at the start of the cycle.
//   Grant is registered: it is high on the clock edge that samples the fire rise (latency 1).
//     On that same edge: slot_busy[s] <= 1, slot_owner[s] <= i, ammo[i] <= ammo[i] - 1.
//   Tank FSM, per tank (READY, COOL, EMPTY):
//     READY -grant-> COOL; cool_cnt loaded with COOLDOWN.
//     COOL: cool_cnt decrements each cycle.
//       cnt == 1 -> READY if ammo != 0, else EMPTY.
//       Next shot is possible COOLDOWN cycles after a grant.
//     EMPTY: reload rise -> READY.
//     A reload rise in any state sets ammo <= AMMO_MAX.
//       READY/COOL keep their state; cooldown is not shortened.
//   Slot free:
//     slot_done[s] clears slot_busy[s] on the next edge.
//     slot_done on an idle slot is ignored.
//     A slot freed this cycle is not grantable until the next cycle.
//   Simultaneous events:
//     Reload rise and fire rise of the same tank in one cycle: reload wins, no grant.
//     Both tanks target the last free slot: arbitration decides; loser waits.
//   Counters saturate, never wrap: ammo does not go below 0; cool_cnt stops at 0.
// CONFIGURATION
//   LIFETIME_TIMEOUT_EN defined:
//     Each slot has a 10-bit age counter, loaded with LIFETIME on grant and decremented per frame.
//     At 1 the slot frees, exactly as slot_done does.
//     slot_done and timeout in the same cycle free the slot once.
//   LIFETIME_TIMEOUT_EN undefined:
//     No age counters; slots free only on slot_done.
//     The LIFETIME parameter is ignored.
// TESTING
//   1. Reset, then fire_req[0] 0->1 -> next edge grant = 01, grant_slot = 0, slot_busy = 0001, ammo0 = 4.
//   2. Both rise in the same cycle from reset -> grant = 01 slot 0.
//      Tank B is granted slot 1 on the following cycle.
//      On the next simultaneous rise, B wins first.
//   3. Tank A fires at t; rises at t+10 and t+29 -> no grant; rise at t+30 -> grant.
//   4. All 4 slots busy; tank B rises -> no grant.
//      slot_done = 0100 -> B granted slot 2 one cycle after the free.
//   5. Five grants for tank A -> ammo0 = 0, FSM EMPTY, further rises ignored.
//      reload_req[0] rise -> ammo0 = 5, next rise granted.
//   6. LIFETIME_TIMEOUT_EN, LIFETIME = 3: grant at t -> slot_busy clears at t+3.
//      Assert Reset_n low mid-flight -> all outputs at reset values immediately.

Source files
------------

// File: rtl/shell_slot_arbiter.sv
// Shares a pool of projectile slots between two tanks, granting one shot per frame with ammo/cooldown rules.
// Optional per-slot lifetime timeout is enabled by defining LIFETIME_TIMEOUT_EN.
module shell_slot_arbiter #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned AMMO_MAX  = 5,
  parameter int unsigned COOLDOWN  = 30,
  parameter int unsigned LIFETIME  = 120,
  localparam int unsigned SW = $clog2(NUM_SLOTS)
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  input  logic [1:0]           fire_req,
  input  logic [1:0]           reload_req,
  input  logic [NUM_SLOTS-1:0] slot_done,
  output logic [1:0]           grant,
  output logic [SW-1:0]        grant_slot,
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic [NUM_SLOTS-1:0] slot_owner,
  output logic [3:0]           ammo0,
  output logic [3:0]           ammo1
);

  if (NUM_SLOTS < 2 || NUM_SLOTS > 8 || AMMO_MAX < 1 || AMMO_MAX > 15 ||
      COOLDOWN < 1 || COOLDOWN > 255 || LIFETIME < 1 || LIFETIME > 1023) begin : g_bad_params
    $error("shell_slot_arbiter: parameter out of legal range");
  end

  typedef enum logic [1:0] {READY, COOL, EMPTY} tank_state_t;

  tank_state_t [1:0]    state_q, state_d;
  logic [1:0][7:0]      cool_q, cool_d;
  logic [1:0][3:0]      ammo_q, ammo_d;
  logic [1:0]           fire_q, reload_q, pend_q, pend_d;
  logic [1:0]           fire_rise, reload_rise, ready, elig, win;
  logic                 ptr_q, ptr_d;
  logic                 any_free;
  logic [SW-1:0]        free_idx;
  logic [NUM_SLOTS-1:0] grant_oh, slot_freed, busy_d, owner_d;

  always_comb begin
    fire_rise   = fire_req & ~fire_q;
    reload_rise = reload_req & ~reload_q;
    any_free    = ~&slot_busy;
    free_idx    = '0;
    for (int unsigned s = NUM_SLOTS; s > 0; s--) begin
      if (!slot_busy[s-1]) free_idx = SW'(s - 1);
    end
    // A COOL tank on its final count leaves COOL this edge, so it may fire on the same edge.
    for (int unsigned i = 0; i < 2; i++) begin
      ready[i] = (state_q[i] == READY) || (state_q[i] == COOL && cool_q[i] <= 8'd1);
      elig[i]  = (pend_q[i] | fire_rise[i]) & ready[i] & (ammo_q[i] != '0) &
                 any_free & ~reload_rise[i];
    end
    win   = elig;
    ptr_d = ptr_q;
    if (&elig) begin
      win   = ptr_q ? 2'b10 : 2'b01;
      ptr_d = ~ptr_q;
    end
    pend_d   = (pend_q | fire_rise) & ~win & ~reload_rise;
    grant_oh = (|win) ? (NUM_SLOTS'(1) << free_idx) : '0;
  end

  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    ammo_d  = ammo_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (reload_rise[i])  ammo_d[i] = 4'(AMMO_MAX);
      else if (win[i])     ammo_d[i] = ammo_q[i] - 4'd1;
      case (state_q[i])
        READY: begin
          if (win[i]) begin
            state_d[i] = COOL;
            cool_d[i]  = 8'(COOLDOWN);
          end
        end
        COOL: begin
          if (cool_q[i] <= 8'd1) begin
            if (win[i]) begin
              state_d[i] = COOL;
              cool_d[i]  = 8'(COOLDOWN);
            end else begin
              cool_d[i]  = '0;
              state_d[i] = (ammo_q[i] != '0 || reload_rise[i]) ? READY : EMPTY;
            end
          end else begin
            cool_d[i] = cool_q[i] - 8'd1;
          end
        end
        EMPTY: begin
          if (reload_rise[i]) state_d[i] = READY;
        end
        default: state_d[i] = READY;
      endcase
    end
  end

`ifdef LIFETIME_TIMEOUT_EN
  logic [NUM_SLOTS-1:0][9:0] age_q, age_d;
  logic [NUM_SLOTS-1:0]      timeout;

  always_comb begin
    age_d   = age_q;
    timeout = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      timeout[s] = slot_busy[s] && (age_q[s] == 10'd1);
      if (grant_oh[s])           age_d[s] = 10'(LIFETIME);
      else if (age_q[s] != '0)   age_d[s] = age_q[s] - 10'd1;
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) age_q <= '0;
    else          age_q <= age_d;
  end

  assign slot_freed = slot_done | timeout;
`else
  assign slot_freed = slot_done;
`endif

  always_comb begin
    busy_d  = (slot_busy & ~slot_freed) | grant_oh;
    owner_d = slot_owner;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (grant_oh[s]) owner_d[s] = win[1];
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fire_q     <= '0;
      reload_q   <= '0;
      pend_q     <= '0;
      ptr_q      <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= READY;
        cool_q[i]  <= '0;
        ammo_q[i]  <= 4'(AMMO_MAX);
      end
      slot_busy  <= '0;
      slot_owner <= '0;
      grant      <= '0;
      grant_slot <= '0;
    end else begin
      fire_q     <= fire_req;
      reload_q   <= reload_req;
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      state_q    <= state_d;
      cool_q     <= cool_d;
      ammo_q     <= ammo_d;
      slot_busy  <= busy_d;
      slot_owner <= owner_d;
      grant      <= win;
      grant_slot <= (|win) ? free_idx : '0;
    end
  end

  assign ammo0 = ammo_q[0];
  assign ammo1 = ammo_q[1];

endmodule
